video_eth_tx_sched: RTL and testbench

//  Sole owner of the GMII TX byte port and the shared CRC32 engine. Schedules frames from the ARP TX

---
 rtl/video_eth_pkg.sv | 33 +++
 rtl/video_eth_tx_mux.sv | 55 +++++
 rtl/video_eth_tx_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_video_eth_tx_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_eth_pkg.sv
// Shared encodings for the video Ethernet TX scheduler and its byte/CRC mux.
// Latency: none (types, constants and one helper only).
// Backpressure: none.
package video_eth_pkg;

  // One-hot scheduler states.
  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_ARB      = 5'b00010,
    ST_WAIT_ARP = 5'b00100,
    ST_WAIT_UDP = 5'b01000,
    ST_IFG      = 5'b10000
  } state_t;

  // Which TX engine currently owns the GMII port and the CRC engine.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_ARP  = 2'd1,
    OWNER_UDP  = 2'd2
  } owner_t;

  localparam logic ARP_TYPE_REQ = 1'b0;
  localparam logic ARP_TYPE_REP = 1'b1;

  localparam int DEFAULT_IFG_CYC     = 12;
  localparam int DEFAULT_TIMEOUT_CYC = 4096;

  // True while a granted frame is on the wire.
  function automatic logic is_wait(input state_t s);
    return (s == ST_WAIT_ARP) || (s == ST_WAIT_UDP);
  endfunction

endpackage

// File: rtl/video_eth_tx_mux.sv
// GMII byte mux (registered) and CRC control mux (combinational) selected by the frame owner.
// Latency: gmii_tx_en/gmii_txd lag the owner's inputs by 1 cycle; crc_en/crc_clr are same-cycle.
// Backpressure: none; non-owner inputs are discarded, sel = OWNER_NONE forces idle outputs.
module video_eth_tx_mux
  import video_eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       force_clr,
  input  logic       arp_gmii_en,
  input  logic [7:0] arp_gmii_d,
  input  logic       udp_gmii_en,
  input  logic [7:0] udp_gmii_d,
  input  logic       arp_crc_en,
  input  logic       arp_crc_clr,
  input  logic       udp_crc_en,
  input  logic       udp_crc_clr,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       crc_en,
  output logic       crc_clr
);

  // Register the owner's byte stream; everything else drives an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
    end else if (sel == OWNER_ARP) begin
      gmii_tx_en <= arp_gmii_en;
      gmii_txd   <= arp_gmii_d;
    end else if (sel == OWNER_UDP) begin
      gmii_tx_en <= udp_gmii_en;
      gmii_txd   <= udp_gmii_d;
    end else begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
    end
  end

  // CRC controls follow the owner directly; a watchdog abort forces a clear.
  always_comb begin
    crc_en  = 1'b0;
    crc_clr = force_clr;
    if (sel == OWNER_ARP) begin
      crc_en  = arp_crc_en;
      crc_clr = force_clr | arp_crc_clr;
    end else if (sel == OWNER_UDP) begin
      crc_en  = udp_crc_en;
      crc_clr = force_clr | udp_crc_clr;
    end
  end

endmodule

// File: rtl/video_eth_tx_sched.sv
// Arbitrates ARP and UDP video TX engines onto one GMII port, answers ARP requests, learns the peer.
// Latency: pending request -> start pulse in 1 cycle from IDLE; IFG_CYC idle cycles after each frame.
// Backpressure: udp_req is held by the UDP engine until udp_gnt; frames stall only behind IFG/other owner.
// Optional: define ARP_PERIODIC_REQ_EN to re-issue ARP requests every ARP_PERIOD cycles.
module video_eth_tx_sched
  import video_eth_pkg::*;
#(
  parameter int IFG_CYC     = DEFAULT_IFG_CYC,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
`ifdef ARP_PERIODIC_REQ_EN
  ,
  parameter int unsigned ARP_PERIOD = 125000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        udp_req,
  output logic        udp_gnt,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  input  logic        arp_tx_done,
  input  logic        udp_tx_done,
  input  logic        arp_gmii_en,
  input  logic [7:0]  arp_gmii_d,
  input  logic        udp_gmii_en,
  input  logic [7:0]  udp_gmii_d,
  input  logic        arp_crc_en,
  input  logic        arp_crc_clr,
  input  logic        udp_crc_en,
  input  logic        udp_crc_clr,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        crc_en,
  output logic        crc_clr,
  output logic        peer_valid,
  output logic        tx_timeout
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int IFG_W = $clog2(IFG_CYC + 1);

  state_t             state;
  owner_t             owner;
  owner_t             mux_sel;
  logic               started;
  logic               rep_pend;
  logic               req_pend;
  logic               rep_set;
  logic               req_set;
  logic               rep_now;
  logic               req_now;
  logic               serve_rep;
  logic               serve_req;
  logic               owner_done;
  logic [WD_W-1:0]    wd_cnt;
  logic [IFG_W-1:0]   ifg_cnt;
  logic               upd_pend;
  logic [47:0]        upd_mac;
  logic [31:0]        upd_ip;

  // A received request must be answered; a request set this cycle already counts in IDLE.
  assign rep_set = arp_rx_done && (arp_rx_type == ARP_TYPE_REQ);
  assign rep_now = rep_pend || rep_set;
  assign req_now = req_pend || req_set;

  // ARB retires exactly the flag it granted, identified by the registered owner/type.
  assign serve_rep = (state == ST_ARB) && (owner == OWNER_ARP) && (arp_tx_type == ARP_TYPE_REP);
  assign serve_req = (state == ST_ARB) && (owner == OWNER_ARP) && (arp_tx_type == ARP_TYPE_REQ);

  // Only the current owner's done ends a frame.
  assign owner_done = (state == ST_WAIT_ARP) ? arp_tx_done :
                      (state == ST_WAIT_UDP) ? udp_tx_done : 1'b0;

  // The port is only connected while a frame is in flight.
  assign mux_sel = is_wait(state) ? owner : OWNER_NONE;

`ifdef ARP_PERIODIC_REQ_EN
  logic [31:0] per_cnt;
  logic [2:0]  per_div;
  logic        per_tick;
  logic        per_hit;

  // Full rate while unresolved, 1/8 rate as a slow refresh once the peer is known.
  assign per_tick = !peer_valid || (per_div == 3'd7);
  assign per_hit  = per_tick && (per_cnt == 32'(ARP_PERIOD - 1));
  assign req_set  = !started || per_hit;

  // Free-running period counter that wraps to 0 on each request.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= 32'd0;
      per_div <= 3'd0;
    end else begin
      per_div <= per_div + 3'd1;
      if (per_tick) begin
        per_cnt <= per_hit ? 32'd0 : per_cnt + 32'd1;
      end
    end
  end
`else
  assign req_set = !started;
`endif

  // Pending flags: a new set always wins over the ARB clear so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      started  <= 1'b0;
      rep_pend <= 1'b0;
      req_pend <= 1'b0;
    end else begin
      started <= 1'b1;
      if (rep_set) begin
        rep_pend <= 1'b1;
      end else if (serve_rep) begin
        rep_pend <= 1'b0;
      end
      if (req_set) begin
        req_pend <= 1'b1;
      end else if (serve_req) begin
        req_pend <= 1'b0;
      end
    end
  end

  // Scheduler FSM with registered start pulses, watchdog and IFG timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWNER_NONE;
      arp_tx_en   <= 1'b0;
      arp_tx_type <= ARP_TYPE_REQ;
      udp_gnt     <= 1'b0;
      tx_timeout  <= 1'b0;
      wd_cnt      <= '0;
      ifg_cnt     <= '0;
    end else begin
      arp_tx_en  <= 1'b0;
      udp_gnt    <= 1'b0;
      tx_timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rep_now) begin
            state       <= ST_ARB;
            owner       <= OWNER_ARP;
            arp_tx_en   <= 1'b1;
            arp_tx_type <= ARP_TYPE_REP;
          end else if (req_now) begin
            state       <= ST_ARB;
            owner       <= OWNER_ARP;
            arp_tx_en   <= 1'b1;
            arp_tx_type <= ARP_TYPE_REQ;
          end else if (udp_req) begin
            state   <= ST_ARB;
            owner   <= OWNER_UDP;
            udp_gnt <= 1'b1;
          end
        end
        ST_ARB: begin
          wd_cnt <= '0;
          state  <= (owner == OWNER_UDP) ? ST_WAIT_UDP : ST_WAIT_ARP;
        end
        ST_WAIT_ARP, ST_WAIT_UDP: begin
          if (owner_done) begin
            state   <= ST_IFG;
            ifg_cnt <= '0;
          end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            // Abort: the served request is dropped, not retried.
            state      <= ST_IFG;
            ifg_cnt    <= '0;
            tx_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ST_IFG: begin
          if (ifg_cnt == IFG_W'(IFG_CYC - 1)) begin
            state <= ST_IDLE;
            owner <= OWNER_NONE;
          end else begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          owner <= OWNER_NONE;
        end
      endcase
    end
  end

  // Peer learning; updates during an ARP frame are parked and applied in the following IFG
  // so the ARP engine never sees its addresses change mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      des_mac    <= 48'd0;
      des_ip     <= 32'd0;
      peer_valid <= 1'b0;
      upd_pend   <= 1'b0;
      upd_mac    <= 48'd0;
      upd_ip     <= 32'd0;
    end else if (arp_rx_done && (state != ST_WAIT_ARP)) begin
      des_mac    <= src_mac;
      des_ip     <= src_ip;
      peer_valid <= 1'b1;
      upd_pend   <= 1'b0;
    end else if (arp_rx_done) begin
      upd_pend <= 1'b1;
      upd_mac  <= src_mac;
      upd_ip   <= src_ip;
    end else if (upd_pend && (state == ST_IFG)) begin
      des_mac    <= upd_mac;
      des_ip     <= upd_ip;
      peer_valid <= 1'b1;
      upd_pend   <= 1'b0;
    end
  end

  video_eth_tx_mux u_mux (
    .clk         (clk),
    .rst         (rst),
    .sel         (mux_sel),
    .force_clr   (tx_timeout),
    .arp_gmii_en (arp_gmii_en),
    .arp_gmii_d  (arp_gmii_d),
    .udp_gmii_en (udp_gmii_en),
    .udp_gmii_d  (udp_gmii_d),
    .arp_crc_en  (arp_crc_en),
    .arp_crc_clr (arp_crc_clr),
    .udp_crc_en  (udp_crc_en),
    .udp_crc_clr (udp_crc_clr),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .crc_en      (crc_en),
    .crc_clr     (crc_clr)
  );

endmodule

// File: tb/tb_video_eth_tx_sched.sv
// Directed bench for video_eth_tx_sched: startup request, reply priority, IFG, watchdog, learning, reset.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// With ARP_PERIODIC_REQ_EN defined it instead checks the periodic request spacing.
module tb_video_eth_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        arp_rx_done, arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        udp_req, udp_gnt;
  logic        arp_tx_en, arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        arp_tx_done, udp_tx_done;
  logic        arp_gmii_en, udp_gmii_en;
  logic [7:0]  arp_gmii_d, udp_gmii_d;
  logic        arp_crc_en, arp_crc_clr, udp_crc_en, udp_crc_clr;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        crc_en, crc_clr, peer_valid, tx_timeout;

  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   n;
  logic saw_en;
  int   tp [0:3];
  int   np;
  int   done_at;

  always #5 clk = ~clk;

`ifdef ARP_PERIODIC_REQ_EN
  video_eth_tx_sched #(.ARP_PERIOD(100)) dut (
`else
  video_eth_tx_sched dut (
`endif
    .clk(clk), .rst(rst),
    .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
    .src_mac(src_mac), .src_ip(src_ip),
    .udp_req(udp_req), .udp_gnt(udp_gnt),
    .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
    .des_mac(des_mac), .des_ip(des_ip),
    .arp_tx_done(arp_tx_done), .udp_tx_done(udp_tx_done),
    .arp_gmii_en(arp_gmii_en), .arp_gmii_d(arp_gmii_d),
    .udp_gmii_en(udp_gmii_en), .udp_gmii_d(udp_gmii_d),
    .arp_crc_en(arp_crc_en), .arp_crc_clr(arp_crc_clr),
    .udp_crc_en(udp_crc_en), .udp_crc_clr(udp_crc_clr),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .crc_en(crc_en), .crc_clr(crc_clr),
    .peer_valid(peer_valid), .tx_timeout(tx_timeout)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    arp_rx_done = 0; arp_rx_type = 0; src_mac = 0; src_ip = 0;
    udp_req = 0; arp_tx_done = 0; udp_tx_done = 0;
    arp_gmii_en = 0; arp_gmii_d = 0; udp_gmii_en = 0; udp_gmii_d = 0;
    arp_crc_en = 0; arp_crc_clr = 0; udp_crc_en = 0; udp_crc_clr = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_gmii_en", gmii_tx_en, 0);
    chk("rst_arp_tx_en", arp_tx_en, 0);
    chk("rst_udp_gnt", udp_gnt, 0);
    chk("rst_des_mac", des_mac, 0);
    chk("rst_des_ip", des_ip, 0);
    chk("rst_peer_valid", peer_valid, 0);
    chk("rst_tx_timeout", tx_timeout, 0);
    chk("rst_crc_clr", crc_clr, 0);
    rst = 1'b0;

`ifdef ARP_PERIODIC_REQ_EN
    // Periodic requests before any peer is learned
    np = 0;
    done_at = -1;
    for (int t = 1; t <= 450 && np < 4; t++) begin
      tick();
      arp_tx_done = (t == done_at);
      if (arp_tx_en) begin
        tp[np] = t;
        np++;
        done_at = t + 4;
        chk("per_type_req", arp_tx_type, 0);
      end
    end
    chk("per_pulse_count", np, 4);
    chk("per_interval_a", tp[2] - tp[1], 100);
    chk("per_interval_b", tp[3] - tp[2], 100);
`else
    // Startup request within 2 cycles of release
    n = 0;
    while (!arp_tx_en && n < 4) begin tick(); n++; end
    chk("startup_within_2", (arp_tx_en && n <= 2), 1);
    chk("startup_type_req", arp_tx_type, 0);
    chk("startup_des_mac", des_mac, 0);
    chk("startup_peer_valid", peer_valid, 0);

    // ARP owns the port; UDP bytes and CRC clear are ignored
    arp_gmii_en = 1; arp_gmii_d = 8'h55; arp_crc_en = 1;
    udp_gmii_en = 1; udp_gmii_d = 8'hAA; udp_crc_clr = 1;
    tick();
    chk("arp_en_one_cycle", arp_tx_en, 0);
    chk("crc_en_arp", crc_en, 1);
    chk("crc_clr_nonowner", crc_clr, 0);
    tick();
    chk("arp_byte_55", {gmii_tx_en, gmii_txd}, {1'b1, 8'h55});

    // Spurious UDP done during the ARP frame
    arp_gmii_d = 8'h5D; udp_tx_done = 1;
    tick();
    udp_tx_done = 0;
    chk("arp_byte_5d", {gmii_tx_en, gmii_txd}, {1'b1, 8'h66 ^ 8'h3B});
    arp_gmii_d = 8'h66;
    tick();
    chk("spurious_done_ignored", {gmii_tx_en, gmii_txd}, {1'b1, 8'h66});

    // ARP done with UDP pending: 12 quiet IFG cycles, then grant
    arp_tx_done = 1; arp_gmii_en = 0; arp_crc_en = 0; udp_req = 1;
    n = 0; saw_en = 0;
    while (!udp_gnt && n < 30) begin
      tick(); arp_tx_done = 0; n++;
      if (gmii_tx_en) saw_en = 1;
    end
    chk("ifg_to_gnt_cycles", n, 14);
    chk("ifg_gmii_quiet", saw_en, 0);

    // Watchdog: UDP never finishes
    udp_req = 0;
    tick();
    chk("udp_gnt_one_cycle", udp_gnt, 0);
    n = 1;
    while (!tx_timeout && n < 5000) begin tick(); n++; end
    chk("timeout_cycles", n, 4097);
    chk("timeout_crc_clr", crc_clr, 1);
    tick();
    chk("timeout_one_cycle", tx_timeout, 0);
    chk("crc_clr_one_cycle", crc_clr, 0);

    // Re-armed UDP request is served after the IFG
    udp_req = 1;
    n = 0;
    while (!udp_gnt && n < 30) begin tick(); n++; end
    chk("rearm_gnt_cycles", n, 12);
    udp_req = 0; udp_gmii_d = 8'hC3; arp_gmii_en = 1; arp_gmii_d = 8'h99;
    tick();
    tick();
    chk("udp_byte_c3", {gmii_tx_en, gmii_txd}, {1'b1, 8'hC3});
    arp_tx_done = 1;
    tick();
    arp_tx_done = 0; udp_gmii_d = 8'hC4;
    tick();
    chk("nonowner_done_ignored", {gmii_tx_en, gmii_txd}, {1'b1, 8'hC4});
    udp_tx_done = 1; udp_gmii_en = 0; arp_gmii_en = 0;
    tick();
    udp_tx_done = 0;
    repeat (16) tick();

    // ARP request and UDP request in the same cycle: reply first, peer learned
    arp_rx_done = 1; arp_rx_type = 0;
    src_mac = 48'h001122AABBCC; src_ip = 32'hC0A80166; udp_req = 1;
    tick();
    arp_rx_done = 0;
    chk("reply_start", arp_tx_en, 1);
    chk("reply_type", arp_tx_type, 1);
    chk("reply_before_udp", udp_gnt, 0);
    chk("learn_peer_valid", peer_valid, 1);
    chk("learn_des_ip", des_ip, 32'hC0A80166);
    chk("learn_des_mac", des_mac, 48'h001122AABBCC);
    arp_gmii_en = 1; arp_gmii_d = 8'h77; udp_gmii_en = 1; udp_gmii_d = 8'hEE;
    tick();
    chk("reply_type_held", arp_tx_type, 1);

    // A reply received mid-frame is parked until the IFG
    arp_rx_done = 1; arp_rx_type = 1;
    src_mac = 48'h0A0B0C0D0E0F; src_ip = 32'h0A000001;
    tick();
    arp_rx_done = 0; src_mac = 0; src_ip = 0;
    chk("no_udp_bytes_in_arp", {gmii_tx_en, gmii_txd}, {1'b1, 8'h77});
    chk("learn_blocked", des_mac, 48'h001122AABBCC);
    arp_tx_done = 1; arp_gmii_en = 0;
    tick();
    arp_tx_done = 0;
    tick();
    chk("learn_applied_mac", des_mac, 48'h0A0B0C0D0E0F);
    chk("learn_applied_ip", des_ip, 32'h0A000001);
    n = 2;
    while (!udp_gnt && n < 30) begin tick(); n++; end
    chk("udp_after_reply", n, 14);

    // Synchronous reset mid-frame
    udp_req = 0; udp_gmii_d = 8'h3C;
    tick();
    tick();
    chk("udp_frame_live", {gmii_tx_en, gmii_txd}, {1'b1, 8'h3C});
    rst = 1;
    tick();
    chk("rst_midframe_gmii_en", gmii_tx_en, 0);
    chk("rst_midframe_des_mac", des_mac, 0);
    chk("rst_midframe_peer", peer_valid, 0);
    rst = 0; udp_gmii_en = 0;
    n = 0;
    while (!arp_tx_en && n < 4) begin tick(); n++; end
    chk("restart_req_within_2", (arp_tx_en && n <= 2), 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
